i2c_master_write: RTL and testbench
===================================

# i2c_master_write

Single-shot I2C bus master that performs one 7-bit-address write transaction of one data byte after reset release. The sequence is START, address+W, ACK, data, ACK, STOP, then `done`. It sits between the system logic and the shared SCL/SDA wires, with a companion I2C slave on the same wires. No clock stretching, arbitration or read support.

## Interface
- `CLK_DIV`, default 1: `clk` cycles per SCL quarter-period (≥1). SCL period is 4·CLK_DIV cycles.
- `clk` input, 1 bit: single system clock; all state changes on the rising edge.
- `reset_n` input, 1 bit: reset is asynchronous and active-low.
- `scl` output, 1 bit: push-pull SCL (master is the only SCL driver).
- `sda` inout, 1 bit: open-drain SDA; the master drives only 1'b0 or 1'bz, and the bus needs an external pull-up.
- `data_in` input, 8 bits: data byte, sent MSB first.
- `slave_addr` input, 8 bits: `slave_addr[6:0]` is the 7-bit target address; bit 7 is ignored.
- `done` output, 1 bit: high once STOP has completed; held until reset.
- `nack` output, 1 bit: high with `done` if either ACK slot read SDA ≠ 0.

## Operation
- Reset values: `scl`=1, `sda` released (z), `done`=0, `nack`=0, state IDLE.
- States: IDLE → START → ADDR → ADDR_ACK → DATA → DATA_ACK → STOP → DONE.
- IDLE lasts exactly one phase after reset deassertion, then the block goes to START automatically.
- Address byte is {`slave_addr[6:0]`, 1'b0}. For `slave_addr`=8'h50 the address byte is 8'hA0.
- Inputs are captured into shift registers on IDLE→START. Later input changes have no effect.
- Each bit slot is 4 phases:
  - Q0: SCL low; SDA updated.
  - Q1: SCL low.
  - Q2: SCL high.
  - Q3: SCL high.
- SDA sampling: ACK is sampled at the end of Q2. ACK is valid only if SDA==0; 1 or z counts as NACK.
- During ACK slots the master releases SDA.
- START phases (SDA, SCL): (z,1), (0,1), (0,1), (0,0).
- STOP phases (SDA, SCL): (0,0), (0,1), (0,1), (z,1).
- Address NACK: skip DATA and DATA_ACK, go directly to STOP, set `nack`.
- Data NACK: go to STOP and set `nack`.
- DONE: `scl`=1, SDA released, `done`=1. The block stays in DONE until reset; there is no restart.
- Reset asserted mid-transaction: outputs return to reset values immediately (asynchronously). This may produce an illegal bus condition, which the block accepts. The transaction restarts from IDLE after release.

## Timing
- A phase lasts CLK_DIV clocks, counted by a `clk`-enable divider.
- Total transaction with ACKs: 1 (IDLE) + 4 (START) + 36 (ADDR+ACK) + 36 (DATA+ACK) + 4 (STOP) = 81 phases.
- `done` rises on the clock edge ending phase 81, i.e. 81·CLK_DIV rising edges after the first edge with `reset_n`=1.
- With an address NACK the transaction is 45 phases.
- SDA changes only while SCL is low, except at START and STOP edges.
- `done` and `nack` rise in the same cycle; both are registered outputs.

## Structure
- Shared package `i2c_pkg`:
  - state enum;
  - phase count constant (4);
  - bits per byte (8);
  - R/W bit value for write (1'b0).
- Sub-module `i2c_phase_gen`: CLK_DIV counter producing a one-cycle `phase_tick` and a 2-bit quarter index.
- Top level holds:
  - FSM;
  - 8-bit shift register and 3-bit bit counter;
  - open-drain driver: `assign sda = sda_low ? 1'b0 : 1'bz`.

## Test plan
- Reset held, CLK_DIV=1 → `scl`=1, `sda`=z, `done`=0, `nack`=0 throughout.
- Addr 8'h50, data 8'hA5, responder ACKs both → bus shows START, 8'hA0, ACK, 8'hA5, ACK, STOP. `done`=1 and `nack`=0 at phase 81.
- Pull-up only, no responder → address NACK, STOP at phase 45, `done`=1, `nack`=1.
- Address ACKed, data NACKed → full 81-phase sequence, `nack`=1.
- CLK_DIV=3 → SCL period 12 clocks, `done` at 243 cycles. Protocol checker confirms SDA is stable while SCL is high outside START/STOP.
- Reset pulsed during DATA → outputs return to reset values asynchronously. A fresh 81-phase transaction completes after release.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-shot I2C write master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP,
    DONE
  } state_e;

  localparam int         PHASES_PER_BIT = 4;
  localparam int         BITS_PER_BYTE  = 8;
  localparam logic       RW_WRITE       = 1'b0;

  localparam logic [1:0] LAST_QTR       = 2'(PHASES_PER_BIT - 1);
  localparam logic [1:0] ACK_SAMPLE_QTR = 2'd2;
  localparam logic [2:0] LAST_BIT       = 3'(BITS_PER_BYTE - 1);

endpackage

// File: rtl/i2c_master_write_if.sv
// System-side signals of the I2C write master; SDA stays a plain inout wire on the top level.
interface i2c_master_write_if;

  logic       scl;
  logic [7:0] data_in;
  logic [7:0] slave_addr;
  logic       done;
  logic       nack;

  modport master (
    output scl,
    output done,
    output nack,
    input  data_in,
    input  slave_addr
  );

  modport slave (
    input  scl,
    input  done,
    input  nack,
    output data_in,
    output slave_addr
  );

endinterface

// File: rtl/i2c_phase_gen.sv
// Divides clk into SCL quarter-phases: a one-cycle phase_tick every CLK_DIV clocks
// and the index of the quarter currently in progress.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       phase_tick,
  output logic [1:0] qtr
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    qtr_q, qtr_d;

  always_comb begin
    phase_tick = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d      = phase_tick ? '0 : cnt_q + CW'(1);
    qtr_d      = phase_tick ? qtr_q + 2'd1 : qtr_q;
  end

  // Quarter starts at its last value so the single IDLE phase wraps it to Q0 for START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      qtr_q <= LAST_QTR;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

  assign qtr = qtr_q;

endmodule

// File: rtl/i2c_master_write.sv
// Single-shot I2C master: after reset it writes one data byte to one 7-bit address,
// then parks in DONE with done/nack until the next reset.
module i2c_master_write
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  i2c_master_write_if.master         bus,
  inout  wire                        sda
);

  logic       phase_tick;
  logic [1:0] qtr;
  logic [1:0] qtr_d;

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       ack_err_q, ack_err_d;
  logic       done_q, done_d;
  logic       nack_q, nack_d;
  logic       scl_q, scl_d;
  logic       sda_low_q, sda_low_d;
  logic       addr_msb_unused;

  assign addr_msb_unused = bus.slave_addr[7];

  i2c_phase_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .phase_tick (phase_tick),
    .qtr        (qtr)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    ack_err_d = ack_err_q;
    done_d    = done_q;
    nack_d    = nack_q;

    if (phase_tick) begin
      case (state_q)
        IDLE: begin
          state_d = START;
          shift_d = {bus.slave_addr[6:0], RW_WRITE};
          data_d  = bus.data_in;
        end
        START: begin
          if (qtr == LAST_QTR) state_d = ADDR;
        end
        ADDR, DATA: begin
          if (qtr == LAST_QTR) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // Anything but a driven low (released/pulled-up line) counts as NACK.
          if (qtr == ACK_SAMPLE_QTR) begin
            ack_err_d = ack_err_q | sda;
          end else if (qtr == LAST_QTR) begin
            if (state_q == ADDR_ACK && !ack_err_q) begin
              state_d = DATA;
              shift_d = data_q;
            end else begin
              state_d = STOP;
            end
          end
        end
        STOP: begin
          if (qtr == LAST_QTR) begin
            state_d = DONE;
            done_d  = 1'b1;
            nack_d  = ack_err_q;
          end
        end
        default: state_d = DONE;
      endcase
    end

    // Bus pins are registered: derive them from the phase being entered.
    qtr_d     = phase_tick ? qtr + 2'd1 : qtr;
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_d)
      START: begin
        scl_d     = (qtr_d != LAST_QTR);
        sda_low_d = (qtr_d != 2'd0);
      end
      ADDR, DATA: begin
        scl_d     = qtr_d[1];
        sda_low_d = ~shift_d[7];
      end
      ADDR_ACK, DATA_ACK: begin
        scl_d     = qtr_d[1];
      end
      STOP: begin
        scl_d     = (qtr_d != 2'd0);
        sda_low_d = (qtr_d != LAST_QTR);
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      data_q    <= '0;
      bit_cnt_q <= '0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign bus.scl  = scl_q;
  assign bus.done = done_q;
  assign bus.nack = nack_q;
  assign sda      = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_write.sv
// Bench for i2c_master_write: two masters (CLK_DIV 1 and 3) on separate pulled-up buses,
// each with a clock-sampled responder that decodes bytes, ACKs per mask and flags SDA misuse.
module tb_i2c_master_write;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] addr_tb  = 8'h00;
  logic [7:0] data_tb  = 8'h00;
  logic [1:0] ack_mask = 2'b11;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int DIV = (gi == 0) ? 1 : 3;

    wire        sda;
    wire        scl_w;
    wire        done_w;
    wire        nack_w;
    wire [1:0]  mask = (gi == 0) ? ack_mask : 2'b11;
    logic       resp_low = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       active   = 1'b0;
    logic       in_ack   = 1'b0;
    logic [1:0] byte_idx = 2'd0;
    logic [3:0] bit_cnt  = 4'd0;
    logic [7:0] shreg    = 8'h00;
    logic [7:0] rx_a     = 8'h00;
    logic [7:0] rx_b     = 8'h00;
    int         starts   = 0;
    int         stops    = 0;
    int         proto_err = 0;

    i2c_master_write_if bus_if ();

    pullup (sda);
    assign sda               = resp_low ? 1'b0 : 1'bz;
    assign bus_if.data_in    = data_tb;
    assign bus_if.slave_addr = addr_tb;
    assign scl_w             = bus_if.scl;
    assign done_w            = bus_if.done;
    assign nack_w            = bus_if.nack;

    i2c_master_write #(
      .CLK_DIV (DIV)
    ) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus_if),
      .sda     (sda)
    );

    // SDA edges with SCL high on both samples must be exactly one START then one STOP.
    always @(negedge clk) begin
      if (!rst_n) begin
        prev_scl  <= 1'b1;
        prev_sda  <= 1'b1;
        active    <= 1'b0;
        in_ack    <= 1'b0;
        byte_idx  <= 2'd0;
        bit_cnt   <= 4'd0;
        shreg     <= 8'h00;
        rx_a      <= 8'h00;
        rx_b      <= 8'h00;
        starts    <= 0;
        stops     <= 0;
        proto_err <= 0;
        resp_low  <= 1'b0;
      end else begin
        prev_scl <= scl_w;
        prev_sda <= sda;
        if (prev_scl && scl_w && (prev_sda != sda)) begin
          if (!sda && !active) begin
            starts   <= starts + 1;
            active   <= 1'b1;
            bit_cnt  <= 4'd0;
            in_ack   <= 1'b0;
            byte_idx <= 2'd0;
          end else if (sda && active) begin
            stops  <= stops + 1;
            active <= 1'b0;
          end else begin
            proto_err <= proto_err + 1;
          end
        end else if (active && scl_w && !prev_scl) begin
          if (!in_ack && bit_cnt < 4'd8) begin
            shreg   <= {shreg[6:0], sda};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (byte_idx == 2'd0) rx_a <= {shreg[6:0], sda};
              else                  rx_b <= {shreg[6:0], sda};
            end
          end
        end else if (active && !scl_w && prev_scl) begin
          if (in_ack) begin
            in_ack   <= 1'b0;
            resp_low <= 1'b0;
            bit_cnt  <= 4'd0;
            byte_idx <= byte_idx + 2'd1;
          end else if (bit_cnt == 4'd8) begin
            in_ack   <= 1'b1;
            resp_low <= (byte_idx < 2'd2) && mask[byte_idx[0]];
          end
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] addr, input logic [7:0] dat,
                         input logic [1:0] mask, input int exp_cyc0, input logic exp_nack0,
                         input logic [7:0] exp_a, input logic [7:0] exp_b, input bit chk_b);
    int n0;
    int n1;
    addr_tb  = addr;
    data_tb  = dat;
    ack_mask = mask;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int c = 1; c <= 400 && (n0 == 0 || n1 == 0); c++) begin
      @(posedge clk);
      #1;
      if (c == 4) begin
        addr_tb = ~addr;
        data_tb = ~dat;
      end
      if (n0 == 0 && g_inst[0].done_w) n0 = c;
      if (n1 == 0 && g_inst[1].done_w) n1 = c;
    end
    $display("txn %s: done0@%0d done1@%0d nack0=%0b nack1=%0b rx0=%h/%h rx1=%h/%h", tag,
             n0, n1, g_inst[0].nack_w, g_inst[1].nack_w, g_inst[0].rx_a, g_inst[0].rx_b,
             g_inst[1].rx_a, g_inst[1].rx_b);
    check_eq({tag, ".cyc0"},   n0, exp_cyc0);
    check_eq({tag, ".cyc1"},   n1, 243);
    check_eq({tag, ".nack0"},  g_inst[0].nack_w, exp_nack0);
    check_eq({tag, ".nack1"},  g_inst[1].nack_w, 0);
    check_eq({tag, ".done0"},  g_inst[0].done_w, 1);
    check_eq({tag, ".addr0"},  g_inst[0].rx_a, exp_a);
    if (chk_b) check_eq({tag, ".data0"}, g_inst[0].rx_b, exp_b);
    check_eq({tag, ".addr1"},  g_inst[1].rx_a, exp_a);
    check_eq({tag, ".data1"},  g_inst[1].rx_b, exp_b);
    check_eq({tag, ".start0"}, g_inst[0].starts, 1);
    check_eq({tag, ".stop0"},  g_inst[0].stops, 1);
    check_eq({tag, ".start1"}, g_inst[1].starts, 1);
    check_eq({tag, ".stop1"},  g_inst[1].stops, 1);
    check_eq({tag, ".proto0"}, g_inst[0].proto_err, 0);
    check_eq({tag, ".proto1"}, g_inst[1].proto_err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check_eq("rst.scl0",  g_inst[0].scl_w, 1);
      check_eq("rst.sda0",  g_inst[0].sda, 1);
      check_eq("rst.done0", g_inst[0].done_w, 0);
      check_eq("rst.nack0", g_inst[0].nack_w, 0);
      check_eq("rst.scl1",  g_inst[1].scl_w, 1);
      check_eq("rst.done1", g_inst[1].done_w, 0);
    end

    run_txn("ack_both",  8'h50, 8'hA5, 2'b11, 81, 1'b0, 8'hA0, 8'hA5, 1'b1);
    run_txn("no_resp",   8'h50, 8'hA5, 2'b00, 45, 1'b1, 8'hA0, 8'hA5, 1'b0);
    run_txn("data_nack", 8'hD5, 8'h3C, 2'b01, 81, 1'b1, 8'hAA, 8'h3C, 1'b1);
    run_txn("addr01",    8'h01, 8'hFF, 2'b11, 81, 1'b0, 8'h02, 8'hFF, 1'b1);

    // Phase 54 is DATA bit 3, Q0: SCL low and SDA driving a 0 of 8'hA5.
    addr_tb  = 8'h50;
    data_tb  = 8'hA5;
    ack_mask = 2'b11;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (53) @(posedge clk);
    #2;
    check_eq("pulse.scl_pre", g_inst[0].scl_w, 0);
    check_eq("pulse.sda_pre", g_inst[0].sda, 0);
    rst_n = 1'b0;
    #1;
    check_eq("pulse.scl0",  g_inst[0].scl_w, 1);
    check_eq("pulse.sda0",  g_inst[0].sda, 1);
    check_eq("pulse.done0", g_inst[0].done_w, 0);
    check_eq("pulse.nack0", g_inst[0].nack_w, 0);
    check_eq("pulse.scl1",  g_inst[1].scl_w, 1);
    $display("txn pulse: reset asserted mid-DATA");

    run_txn("after_pulse", 8'h50, 8'hA5, 2'b11, 81, 1'b0, 8'hA0, 8'hA5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
